mux_sweep_ctrl: RTL and testbench

Sequencer that drives the four select/data inputs (A, B, C, D) of the 8-to-1-mux function block, walks all 16 input combinations, and captures the block's two outputs (g, h) into 16-bit truth tables. It compares the captured tables against expected tables supplied at start and reports pass/fail plus the first failing vector. It sits between the function block and the self-test/configuration logic, and replaces a free-running stimulus bench with a synthesizable, repeatable check.

---
 rtl/mux_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_mux_sweep_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_ctrl.sv
// Walks A,B,C,D through all 16 vectors, captures g/h truth tables, checks them.
// Optional MUX_SWEEP_STOP_ON_MISMATCH_EN ends the sweep at the first bad vector.
module mux_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] exp_g,
  input  logic [15:0] exp_h,
  output logic        sel_a,
  output logic        sel_b,
  output logic        sel_c,
  output logic        sel_d,
  input  logic        g_in,
  input  logic        h_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] g_tt,
  output logic [15:0] h_tt,
  output logic        pass,
  output logic [3:0]  mismatch_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_exp_g;
  logic [15:0] r_exp_h;
  logic [15:0] r_g_tt;
  logic [15:0] r_h_tt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_mm_found;
  logic [3:0]  r_mm_idx;

  logic w_mm;
  logic w_last;
  logic w_end;

  assign w_mm   = (g_in != r_exp_g[r_idx])
                | (h_in != r_exp_h[r_idx]);
  assign w_last = (r_idx == 4'd15);

`ifdef MUX_SWEEP_STOP_ON_MISMATCH_EN
  assign w_end = w_last | w_mm;
`else
  assign w_end = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_exp_g    <= '0;
      r_exp_h    <= '0;
      r_g_tt     <= '0;
      r_h_tt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mm_found <= 1'b0;
      r_mm_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_exp_g    <= exp_g;
            r_exp_h    <= exp_h;
            r_g_tt     <= '0;
            r_h_tt     <= '0;
            r_pass     <= 1'b0;
            r_mm_found <= 1'b0;
            r_mm_idx   <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (r_cnt != LP_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt         <= '0;
            r_g_tt[r_idx] <= g_in;
            r_h_tt[r_idx] <= h_in;
            if (w_mm && !r_mm_found) begin
              r_mm_found <= 1'b1;
              r_mm_idx   <= r_idx;
            end
            if (w_end) begin
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= !(r_mm_found || w_mm);
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel_a        = r_idx[3];
  assign sel_b        = r_idx[2];
  assign sel_c        = r_idx[1];
  assign sel_d        = r_idx[0];
  assign busy         = r_busy;
  assign done         = r_done;
  assign g_tt         = r_g_tt;
  assign h_tt         = r_h_tt;
  assign pass         = r_pass;
  assign mismatch_idx = r_mm_idx;

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Bench for mux_sweep_ctrl: S=1 and S=3 instances, table vectors,
// random sweeps against a truth-table reference model.
module tb_mux_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st;
  logic        cur;
  logic [15:0] eg, eh, fg, fh;

  logic        a1, b1, c1, d1, g1, h1;
  logic        busy1, done1, pass1;
  logic [15:0] gtt1, htt1;
  logic [3:0]  mi1;
  logic        a3, b3, c3, d3, g3, h3;
  logic        busy3, done3, pass3;
  logic [15:0] gtt3, htt3;
  logic [3:0]  mi3;
  logic        start1, start3;
  logic [1:0]  pg, ph;

  assign start1 = st & ~cur;
  assign start3 = st & cur;
  assign g1 = fg[{a1, b1, c1, d1}];
  assign h1 = fh[{a1, b1, c1, d1}];

  // S=3 instance sees the function block through a 2-cycle delay
  always @(posedge clk) begin
    pg <= {pg[0], fg[{a3, b3, c3, d3}]};
    ph <= {ph[0], fh[{a3, b3, c3, d3}]};
  end
  assign g3 = pg[1];
  assign h3 = ph[1];

  mux_sweep_ctrl #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .exp_g(eg), .exp_h(eh),
    .sel_a(a1), .sel_b(b1), .sel_c(c1), .sel_d(d1),
    .g_in(g1), .h_in(h1),
    .busy(busy1), .done(done1),
    .g_tt(gtt1), .h_tt(htt1),
    .pass(pass1), .mismatch_idx(mi1)
  );

  mux_sweep_ctrl #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .exp_g(eg), .exp_h(eh),
    .sel_a(a3), .sel_b(b3), .sel_c(c3), .sel_d(d3),
    .g_in(g3), .h_in(h3),
    .busy(busy3), .done(done3),
    .g_tt(gtt3), .h_tt(htt3),
    .pass(pass3), .mismatch_idx(mi3)
  );

  logic [42:0] o1, o3;
  assign o1 = {a1, b1, c1, d1, busy1, done1, gtt1, htt1, pass1, mi1};
  assign o3 = {a3, b3, c3, d3, busy3, done3, gtt3, htt3, pass3, mi3};

  logic [3:0]  c_sel;
  logic        c_busy, c_done, c_pass;
  logic [15:0] c_gtt, c_htt;
  logic [3:0]  c_mi;
  assign c_sel  = cur ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  assign c_busy = cur ? busy3 : busy1;
  assign c_done = cur ? done3 : done1;
  assign c_pass = cur ? pass3 : pass1;
  assign c_gtt  = cur ? gtt3 : gtt1;
  assign c_htt  = cur ? htt3 : htt1;
  assign c_mi   = cur ? mi3 : mi1;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic void model(
    input logic [15:0] mg, mh, xg, xh,
    output logic [15:0] gt, ht,
    output bit ps, output logic [3:0] mi, output int nv);
    gt = '0; ht = '0; ps = 1'b1; mi = '0; nv = 16;
    for (int i = 0; i < 16; i++) begin
      gt[i] = mg[i];
      ht[i] = mh[i];
      if (ps && (mg[i] != xg[i] || mh[i] != xh[i])) begin
        ps = 1'b0;
        mi = 4'(i);
`ifdef MUX_SWEEP_STOP_ON_MISMATCH_EN
        nv = i + 1;
        break;
`endif
      end
    end
  endfunction

  task automatic sweep(input logic [15:0] mg, mh, xg, xh, gte, hte,
                       input bit pse, input logic [3:0] mie,
                       input int nve);
    int s, n;
    bit selok;
    s = cur ? 3 : 1;
    fg = mg; fh = mh; eg = xg; eh = xh;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    chk("busy_rise", c_busy, 1);
    eg = 16'($urandom);
    eh = 16'($urandom);
    n = 0;
    selok = 1'b1;
    while (!c_done && n < 16 * s + 10) begin
      if (c_sel != 4'(n / s)) selok = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    chk("done_edge", n, nve * s);
    chk("sel_walk", selok, 1);
    chk("busy_sel_at_done", {c_busy, c_sel}, 0);
    chk("g_tt", c_gtt, gte);
    chk("h_tt", c_htt, hte);
    chk("pass", c_pass, pse);
    chk("mm_idx", c_mi, mie);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    chk("done_pulse", c_done, 0);
    @(posedge clk);
    #1 chk("start_in_done_ignored", c_busy, 0);
    chk("hold_g_tt", c_gtt, gte);
  endtask

  typedef struct {
    logic [15:0] mg, mh, xg, xh, gt, ht;
    bit          ps;
    logic [3:0]  mi;
    int          nv;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [15:0] gt, ht;
    bit ps;
    logic [3:0] mi;
    int nv, k;

    tbl[0] = '{16'h6996, 16'hF000, 16'h6996, 16'hF000,
               16'h6996, 16'hF000, 1, 0, 16};
`ifdef MUX_SWEEP_STOP_ON_MISMATCH_EN
    tbl[1] = '{16'h6996, 16'hF000, 16'h6997, 16'hF000,
               16'h0000, 16'h0000, 0, 0, 1};
    tbl[2] = '{16'h6996, 16'hF000, 16'h6996, 16'hF100,
               16'h0196, 16'h0000, 0, 8, 9};
`else
    tbl[1] = '{16'h6996, 16'hF000, 16'h6997, 16'hF000,
               16'h6996, 16'hF000, 0, 0, 16};
    tbl[2] = '{16'h6996, 16'hF000, 16'h6996, 16'hF100,
               16'h6996, 16'hF000, 0, 8, 16};
`endif
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 1, 0, 16};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF,
               16'hFFFF, 16'hFFFF, 0, 15, 16};

    rst_n = 1'b0;
    cur = 1'b0;
    fg = 16'h6996; fh = 16'hF000;
    for (int i = 0; i < 3; i++) begin
      st = 1'($urandom);
      eg = 16'($urandom);
      eh = 16'($urandom);
      @(negedge clk);
      chk("reset_outs", {o1, o3}, 0);
    end
    st = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_outs", {o1, o3}, 0);
    end

    for (int i = 0; i < 5; i++)
      sweep(tbl[i].mg, tbl[i].mh, tbl[i].xg, tbl[i].xh,
            tbl[i].gt, tbl[i].ht, tbl[i].ps, tbl[i].mi, tbl[i].nv);

    cur = 1'b1;
    sweep(16'h6996, 16'hF000, 16'h6996, 16'hF000,
          16'h6996, 16'hF000, 1, 0, 16);
    cur = 1'b0;

    // start pulsed mid-sweep must not restart or relatch
    fg = 16'h6996; fh = 16'hF000; eg = 16'h6996; eh = 16'hF000;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    k = 0;
    while (c_sel != 4'd5 && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reach_vec5", k, 5);
    eg = 16'h0000;
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    k++;
    while (!c_done && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("ign_start_edge", k, 16);
    chk("ign_start_pass", {c_pass, c_mi, c_gtt}, {1'b1, 4'd0, 16'h6996});
    @(posedge clk);
    #1;

    // reset asserted mid-sweep
    eg = 16'h6996;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    k = 0;
    while (c_sel != 4'd7 && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reach_vec7", k, 7);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", {o1, o3}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_after_reset", {o1, o3}, 0);
    sweep(16'h6996, 16'hF000, 16'h6996, 16'hF000,
          16'h6996, 16'hF000, 1, 0, 16);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] mg, mh, xg, xh;
      cur = (r % 4 == 3);
      mg = 16'($urandom);
      mh = 16'($urandom);
      xg = mg;
      xh = mh;
      if ($urandom_range(0, 1) == 1) xg[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) xh[$urandom_range(0, 15)] ^= 1'b1;
      model(mg, mh, xg, xh, gt, ht, ps, mi, nv);
      sweep(mg, mh, xg, xh, gt, ht, ps, mi, nv);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
